// File: rtl/instr_fetcher.sv
// Fetch stage: direct-mapped instruction cache with a byte-serial refill from the memory controller.
// Build option FETCH_ICACHE_EN enables the cache; without it every fetch refills and nothing is stored.
module instr_fetcher #(
  parameter int IndexWidth = 6,
  parameter int PcWidth    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PcWidth-1:0] pc_from_iq,
  input  logic               is_empty_from_iq,
  input  logic               is_exception_from_rob,
  input  logic               is_grant_from_mc,
  input  logic               is_byte_from_mc,
  input  logic [7:0]         byte_from_mc,
  output logic               is_request_to_mc,
  output logic [PcWidth-1:0] addr_to_mc,
  output logic               is_stall_to_iq,
  output logic               is_finish_to_iq,
  output logic               is_instr_to_iq,
  output logic [31:0]        instr_to_iq
);
  // state | meaning
  // IDLE  | sample pc from the queue; a hit is delivered on the next cycle
  // MISS  | issue four byte reads, assemble the word little-endian
  // FLUSH | one-cycle abort after a ROB exception; late bytes dropped
  typedef enum logic [1:0] {IDLE, MISS, FLUSH} state_t;

  localparam int TagWidth = PcWidth - IndexWidth - 2;
  localparam int Lines    = 1 << IndexWidth;

  state_t             state;
  logic [PcWidth-1:0] miss_pc;
  logic [1:0]         issue_cnt;
  logic [1:0]         recv_cnt;
  logic [23:0]        asm_word;
  logic               hit;
  logic [31:0]        hit_word;

`ifdef FETCH_ICACHE_EN
  logic [IndexWidth-1:0] req_index;
  logic [TagWidth-1:0]   req_tag;
  logic [IndexWidth-1:0] fill_index;
  logic                  fill_en;
  logic [Lines-1:0]      valid;
  logic [TagWidth-1:0]   tag_arr  [Lines];
  logic [31:0]           data_arr [Lines];

  assign req_index  = pc_from_iq[IndexWidth+1:2];
  assign req_tag    = pc_from_iq[PcWidth-1:IndexWidth+2];
  assign fill_index = miss_pc[IndexWidth+1:2];
  assign hit        = valid[req_index] && (tag_arr[req_index] == req_tag);
  assign hit_word   = data_arr[req_index];

  // The line is written on the same edge that captures the last byte, unless that edge flushes.
  assign fill_en = (state == MISS) && !is_exception_from_rob && is_byte_from_mc && (recv_cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_arr[fill_index]  <= miss_pc[PcWidth-1:IndexWidth+2];
      data_arr[fill_index] <= {byte_from_mc, asm_word};
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_word = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      miss_pc          <= '0;
      issue_cnt        <= '0;
      recv_cnt         <= '0;
      asm_word         <= '0;
      is_request_to_mc <= 1'b0;
      addr_to_mc       <= '0;
      is_stall_to_iq   <= 1'b0;
      is_finish_to_iq  <= 1'b0;
      is_instr_to_iq   <= 1'b0;
      instr_to_iq      <= '0;
    end else begin
      is_finish_to_iq <= 1'b0;
      is_instr_to_iq  <= 1'b0;
      if (is_exception_from_rob) begin
        state            <= FLUSH;
        issue_cnt        <= '0;
        recv_cnt         <= '0;
        is_request_to_mc <= 1'b0;
        is_stall_to_iq   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (!is_empty_from_iq) begin
              miss_pc <= pc_from_iq;
              if (hit) begin
                is_finish_to_iq <= 1'b1;
                is_instr_to_iq  <= 1'b1;
                instr_to_iq     <= hit_word;
              end else begin
                state            <= MISS;
                is_stall_to_iq   <= 1'b1;
                is_request_to_mc <= 1'b1;
                addr_to_mc       <= pc_from_iq;
                issue_cnt        <= '0;
                recv_cnt         <= '0;
              end
            end
          end
          MISS: begin
            if (is_request_to_mc && is_grant_from_mc) begin
              issue_cnt  <= issue_cnt + 2'd1;
              addr_to_mc <= miss_pc + {{(PcWidth-2){1'b0}}, issue_cnt + 2'd1};
              if (issue_cnt == 2'd3) is_request_to_mc <= 1'b0;
            end
            if (is_byte_from_mc) begin
              recv_cnt <= recv_cnt + 2'd1;
              case (recv_cnt)
                2'd0: asm_word[7:0]   <= byte_from_mc;
                2'd1: asm_word[15:8]  <= byte_from_mc;
                2'd2: asm_word[23:16] <= byte_from_mc;
                default: begin
                  is_finish_to_iq <= 1'b1;
                  is_instr_to_iq  <= 1'b1;
                  instr_to_iq     <= {byte_from_mc, asm_word};
                  is_stall_to_iq  <= 1'b0;
                  state           <= IDLE;
                end
              endcase
            end
          end
          FLUSH: begin
            state          <= IDLE;
            is_stall_to_iq <= 1'b0;
          end
          default: begin
            state          <= IDLE;
            is_stall_to_iq <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
